// File: rtl/eoc_pkg.sv
// Shared definitions for the end-of-column hit buffer: column-bus field
// positions, operating mode and the timestamp Gray encoder.
package eoc_pkg;

  // Default field positions inside the column data word
  localparam int unsigned TOT_FIELD_LSB = 5;
  localparam int unsigned TOT_FIELD_MSB = 12;
  localparam int unsigned TOA_FIELD_LSB = 18;
  localparam int unsigned TOA_FIELD_MSB = 26;

  typedef enum logic {
    EOC_TRACK = 1'b0,
    EOC_PC    = 1'b1
  } eoc_mode_e;

  // Binary to reflected Gray code; callers truncate to their own width
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/eoc_hit_buffer_if.sv
// Column-side bus of the end-of-column block: arbiter data/ready toward the
// pixel column and the write port toward the peripheral column FIFO.
interface eoc_hit_buffer_if #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned ADDR_W = 1
);

  logic [DATA_W-1:0]        col_data;
  logic                     shake_hands_col;
  logic [DATA_W+ADDR_W-1:0] col_fifo_data;
  logic                     wr_fifo;
  logic                     fifo_full;

  // master: the end-of-column block
  modport master (
    input  col_data,
    input  fifo_full,
    output shake_hands_col,
    output col_fifo_data,
    output wr_fifo
  );

  // slave: the arbiter and peripheral FIFO around it
  modport slave (
    output col_data,
    output fifo_full,
    input  shake_hands_col,
    input  col_fifo_data,
    input  wr_fifo
  );

endinterface

// File: rtl/eoc_sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head and an
// occupancy counter. Pushes when full and pops when empty are ignored.
module eoc_sync_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and level next-state; pointers wrap naturally (Depth is 2^n)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Control state; reset discards any buffered entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible below the level count
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/eoc_hit_buffer.sv
// End-of-column interface for one pixel column: deduplicates the two-cycle
// data hold, buffers hits against short peripheral back-pressure, tags them
// with the column address, counts drops and drives the Gray timestamp.
module eoc_hit_buffer
  import eoc_pkg::*;
#(
  parameter int unsigned DATA_W   = 27,
  parameter int unsigned ADDR_W   = 1,
  parameter int unsigned COL_ADDR = 0,
  parameter int unsigned TS_W     = 9,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TOT_LSB  = TOT_FIELD_LSB,
  parameter int unsigned TOT_MSB  = TOT_FIELD_MSB,
  parameter int unsigned TOA_LSB  = TOA_FIELD_LSB,
  parameter int unsigned TOA_MSB  = TOA_FIELD_MSB,
  parameter int unsigned OVF_W    = 8
) (
  input  logic                     clk_40MHz,
  input  logic                     rst_n_pixel,
  eoc_hit_buffer_if.master         bus_io,
  input  logic                     mode,
  input  logic                     ts_clr,
  input  logic                     push_flag,
  output logic [TS_W-1:0]          TimeStamp,
  output logic                     push_clk,
  output logic [$clog2(DEPTH):0]   buf_level,
  output logic [OVF_W-1:0]         ovf_cnt
);

  localparam int unsigned OutW = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] ColAddr = ADDR_W'(COL_ADDR);

  eoc_mode_e         mode_e;
  logic [DATA_W-1:0] col_data_dly_q;
  logic              tot_hit, toa_hit, valid, new_hit;
  logic              buf_full, buf_empty, ready, push, pop;
  logic [OutW-1:0]   buf_head;
  logic [OutW-1:0]   out_q, out_d;
  logic              wr_q, wr_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic [TS_W-1:0]   ts_q, ts_d;

  assign mode_e  = eoc_mode_e'(mode);
  assign tot_hit = |bus_io.col_data[TOT_MSB:TOT_LSB];
  assign toa_hit = |bus_io.col_data[TOA_MSB:TOA_LSB];
  assign valid   = (mode_e == EOC_PC) ? tot_hit : (tot_hit | toa_hit);
  // The column holds each hit for two cycles; only the first is new
  assign new_hit = valid & (bus_io.col_data != col_data_dly_q);

  // Readiness comes from the pre-edge level, so a same-cycle pop never
  // admits a push into a full buffer
  assign ready = ~buf_full;
  assign push  = new_hit & ready;
  assign pop   = ~buf_empty & ~bus_io.fifo_full;

  eoc_sync_fifo #(
    .Width (OutW),
    .Depth (DEPTH)
  ) u_buf (
    .clk_i   (clk_40MHz),
    .rst_ni  (rst_n_pixel),
    .push_i  (push),
    .data_i  ({bus_io.col_data, ColAddr}),
    .pop_i   (pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .level_o (buf_level)
  );

  // Next-state for output register, drop counter and timestamp
  always_comb begin
    out_d = out_q;
    wr_d  = pop;
    ovf_d = ovf_q;
    if (pop) out_d = buf_head;
    if (new_hit && !ready && (ovf_q != {OVF_W{1'b1}})) ovf_d = ovf_q + 1'b1;
    ts_d = ts_clr ? '0 : ts_q + 1'b1;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_40MHz or negedge rst_n_pixel) begin
    if (!rst_n_pixel) begin
      col_data_dly_q <= '0;
      out_q          <= '0;
      wr_q           <= 1'b0;
      ovf_q          <= '0;
      ts_q           <= '0;
    end else begin
      col_data_dly_q <= bus_io.col_data;
      out_q          <= out_d;
      wr_q           <= wr_d;
      ovf_q          <= ovf_d;
      ts_q           <= ts_d;
    end
  end

  assign bus_io.col_fifo_data   = out_q;
  assign bus_io.wr_fifo         = wr_q;
  assign bus_io.shake_hands_col = ready;
  assign ovf_cnt                = ovf_q;
  assign push_clk               = push_flag;
  assign TimeStamp              = TS_W'(bin2gray(32'(ts_q)));

endmodule

// File: doc/eoc_hit_buffer.md
Name: eoc_hit_buffer

Overview:
Parametrised next-generation end-of-column interface between one pixel column's last arbiter and the peripheral column FIFO. It detects valid hits on the column bus and deduplicates the column's two-cycle data hold. Hits are buffered in a small local FIFO so a single cycle of peripheral back-pressure does not stall the arbiter, and each hit is tagged with the column address. The block also generates the per-column Gray timestamp, counts dropped hits, and supports tracking and photon-counting modes.

Parameters:
DATA_W, 27, column data width.
ADDR_W, 1, column address tag width.
COL_ADDR, 0, fixed column address appended as the LSBs of output data.
TS_W, 9, timestamp counter width.
DEPTH, 4, local buffer entries, power of 2, minimum 2.
TOT_LSB/TOT_MSB, 5/12, TOT (PC-mode count) field in col_data.
TOA_LSB/TOA_MSB, 18/26, TOA (PC-mode iTOT) field in col_data.
OVF_W, 8, dropped-hit counter width.

Ports:
clk_40MHz  in  1  system clock
rst_n_pixel  in  1  asynchronous, active-low reset
col_data  in  DATA_W  column bus; holds each hit for 2 cycles, then returns to 0
mode  in  1  0 = tracking, 1 = photon counting
ts_clr  in  1  synchronous timestamp clear
push_flag  in  1  mask/pulse/DAC configuration clock enable
fifo_full  in  1  peripheral FIFO full
col_fifo_data  out  DATA_W+ADDR_W  {col_data, COL_ADDR}
wr_fifo  out  1  one-cycle write strobe to the peripheral FIFO
shake_hands_col  out  1  ready to the last arbiter
TimeStamp  out  TS_W  Gray-coded timestamp to the pixel array
push_clk  out  1  equals push_flag
buf_level  out  clog2(DEPTH)+1  current buffer occupancy
ovf_cnt  out  OVF_W  saturating count of dropped hits

Behaviour:
- Reset (rst_n_pixel low, asynchronous): buffer empty, col_fifo_data=0, wr_fifo=0, buf_level=0, ovf_cnt=0, timestamp binary counter=0 (so TimeStamp=0), col_data_d=0. shake_hands_col=1 immediately after reset.
- Valid detection:
  - mode 0: valid = (TOT field != 0) | (TOA field != 0).
  - mode 1: valid = (TOT field != 0) only.
- New hit = valid & (col_data != col_data_d). col_data_d is col_data registered every cycle. A held second cycle is therefore never captured twice.
- shake_hands_col = (buf_level != DEPTH), combinational from the level register.
- Capture: on a new hit with shake_hands_col=1, {col_data, COL_ADDR} is pushed at that clock edge.
- Drop: on a new hit with shake_hands_col=0, nothing is pushed and ovf_cnt increments, saturating at all-ones.
- Drain: when the buffer is non-empty and fifo_full=0, pop the head at the edge. col_fifo_data takes the head value and wr_fifo=1 for that cycle. Otherwise wr_fifo=0 and col_fifo_data holds its last value.
- Latency: a hit captured at edge N appears with wr_fifo=1 after edge N+1 at the earliest. Sustained rate is 1 hit per cycle when fifo_full=0.
- Simultaneous push and pop: both happen, level unchanged. When full, readiness is decided from the pre-edge level, so a concurrent pop does not admit a push.
- fifo_full=1: no pops, and the buffer fills up to DEPTH. Deasserting fifo_full resumes draining the next cycle.
- Timestamp: binary counter increments every cycle and wraps 2^TS_W-1 -> 0.
  - ts_clr=1 loads 0 on the next edge; ts_clr has priority over increment.
  - TimeStamp = bin ^ (bin >> 1), combinational from the register, so adjacent values differ by one bit, including at wrap.
- mode change: affects valid detection from the same cycle. Buffered entries are untouched.
- Reset asserted mid-operation: all buffered entries are discarded, and no wr_fifo pulse occurs during or after reset until a new capture.

Decomposition:
- Package eoc_pkg holds:
  - the field-position constants (TOT_*, TOA_*);
  - a mode enum with values EOC_TRACK=0 and EOC_PC=1;
  - a bin2gray function.
- One sub-module, eoc_sync_fifo: parameterised width/depth synchronous FIFO with push, pop, full, empty and level outputs, and asynchronous reset.
- Hit detection, drop counting, output register and timestamp stay in the top level.

Test Plan:
- Single hit: col_data=0x0000020 held 2 cycles, fifo_full=0, COL_ADDR=1 -> exactly one wr_fifo pulse, one cycle after capture, col_fifo_data=0x0000041.
- Mode filter: col_data with only TOA=0x1FF, TOT=0. Mode 0 -> 1 write. Mode 1 -> 0 writes, ovf_cnt stays 0.
- Back-pressure and overflow:
  - fifo_full=1, then 6 distinct hits separated by zero cycles, DEPTH=4 -> buf_level=4, shake_hands_col=0, ovf_cnt=2.
  - Release fifo_full -> 4 consecutive wr_fifo pulses carrying the first 4 hits in order.
- Saturation: OVF_W=8, 300 drops -> ovf_cnt=255.
- Timestamp:
  - After reset, 511 cycles -> TimeStamp=Gray(511)=0x100; next cycle -> 0x000.
  - Verify a single-bit change on every step.
  - ts_clr at count 37 -> counter 0 on the next edge.
- Reset mid-drain: 3 entries buffered, pulse rst_n_pixel low -> wr_fifo=0, buf_level=0, col_fifo_data=0 asynchronously; no further writes after release.
